// File: rtl/axis_crc32_mpeg2_arb.sv
// Round-robin arbiter sharing one CRC32/MPEG-2 AXI-Stream engine between N_CH frame sources.
// Optional result timeout enabled by defining AXIS_CRC_ARB_TIMEOUT_EN (adds err_timeout, uses MAX_WAIT).
module axis_crc32_mpeg2_arb #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH-1:0]          s_tvalid,
  input  logic [N_CH-1:0]          s_tlast,
  output logic [N_CH-1:0]          s_tready,
  output logic [DATA_W-1:0]        eng_tdata,
  output logic                     eng_tvalid,
  output logic                     eng_tlast,
  input  logic                     eng_tready,
  input  logic [DATA_W-1:0]        eng_crc,
  input  logic                     eng_crc_valid,
  output logic                     eng_crc_ready,
  output logic [DATA_W-1:0]        res_tdata,
  output logic [$clog2(N_CH)-1:0]  res_tid,
  output logic                     res_tvalid,
  input  logic                     res_tready,
  output logic [N_CH-1:0]          grant,
  output logic                     busy
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
  , output logic                   err_timeout
`endif
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_CH-1:0]    grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_found;
  logic [DATA_W-1:0]  res_tdata_d;
  logic [IDX_W-1:0]   res_tid_d;

`ifdef AXIS_CRC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               tmo_d;
`endif

  // Channel index arithmetic modulo N_CH (N_CH need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDX_W'(sum % N_CH);
  endfunction

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!arb_found && s_tvalid[wrap_add(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  // Granted channel is wired straight through to the engine while streaming.
  always_comb begin
    eng_tdata  = '0;
    eng_tvalid = 1'b0;
    eng_tlast  = 1'b0;
    s_tready   = '0;
    if (state_q == STREAM) begin
      eng_tdata        = s_tdata[32'(gidx_q) * DATA_W +: DATA_W];
      eng_tvalid       = s_tvalid[gidx_q];
      eng_tlast        = s_tlast[gidx_q];
      s_tready[gidx_q] = eng_tready;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    res_tdata_d = res_tdata;
    res_tid_d   = res_tid;
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    tmo_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = STREAM;
          grant_d = N_CH'(1) << arb_idx;
          gidx_d  = arb_idx;
        end
      end
      STREAM: begin
        if (eng_tvalid && eng_tready && eng_tlast) begin
          state_d = WAIT_RES;
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      WAIT_RES: begin
        if (eng_crc_valid && eng_crc_ready) begin
          state_d     = RESP;
          res_tdata_d = eng_crc;
          res_tid_d   = gidx_q;
        end
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d     = RESP;
          res_tdata_d = '1;
          res_tid_d   = gidx_q;
          tmo_d       = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (res_tready) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_add(gidx_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      grant         <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      res_tdata     <= '0;
      res_tid       <= '0;
      res_tvalid    <= 1'b0;
      eng_crc_ready <= 1'b0;
      busy          <= 1'b0;
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant         <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      res_tdata     <= res_tdata_d;
      res_tid       <= res_tid_d;
      res_tvalid    <= (state_d == RESP);
      eng_crc_ready <= (state_d == WAIT_RES);
      busy          <= (state_d != IDLE);
`ifdef AXIS_CRC_ARB_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      err_timeout   <= tmo_d;
`endif
    end
  end

endmodule

// File: doc/axis_crc32_mpeg2_arb.md
Name: axis_crc32_mpeg2_arb

Overview:
- Round-robin arbiter that shares one CRC32/MPEG-2 AXI-Stream engine between N_CH requesting AXI-Stream channels.
- Grants one channel for a whole frame (until tlast) and forwards its beats to the engine.
- Waits for the engine's CRC result and returns it on a single result stream tagged with the channel ID.
- Sits between the per-channel packet sources and the shared CRC engine instance.

Parameters:
- N_CH, 4, number of requesting channels (legal range 2..16).
- DATA_W, 32, data width of channel beats and CRC result.
- MAX_WAIT, 1024, result-timeout limit in cycles (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_tdata  in  N_CH*DATA_W  per-channel beat data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  N_CH  per-channel valid.
- s_tlast  in  N_CH  per-channel end of frame.
- s_tready  out  N_CH  per-channel ready.
- eng_tdata  out  DATA_W  beat data to the engine.
- eng_tvalid  out  1  beat valid to the engine.
- eng_tlast  out  1  end of frame to the engine.
- eng_tready  in  1  engine ready.
- eng_crc  in  DATA_W  CRC result from the engine.
- eng_crc_valid  in  1  CRC result valid.
- eng_crc_ready  out  1  result accept to the engine.
- res_tdata  out  DATA_W  CRC result output.
- res_tid  out  $clog2(N_CH)  channel that owns res_tdata.
- res_tvalid  out  1  result valid.
- res_tready  in  1  result ready.
- grant  out  N_CH  one-hot current owner; all zeros when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE, rr_ptr=0, grant=0, busy=0.
  - s_tready=0, eng_tvalid=0, eng_tlast=0, eng_crc_ready=0.
  - res_tvalid=0, res_tdata=0, res_tid=0.
- States: IDLE, STREAM, WAIT_RES, RESP.
- IDLE:
  - Search s_tvalid starting at rr_ptr, ascending, wrapping modulo N_CH.
  - First set bit wins. Register grant/gidx, go to STREAM next cycle (1-cycle arbitration latency).
  - No requests: stay in IDLE.
- STREAM (combinational pass-through of the granted channel g):
  - eng_tdata=s_tdata[g], eng_tvalid=s_tvalid[g], eng_tlast=s_tlast[g], s_tready[g]=eng_tready.
  - All other s_tready bits are 0.
  - A beat transfers when eng_tvalid&&eng_tready. A transferred beat with tlast=1 moves to WAIT_RES.
  - Requests from other channels are ignored until the frame ends. No preemption.
- WAIT_RES:
  - eng_crc_ready=1. All s_tready=0, eng_tvalid=0.
  - On eng_crc_valid: capture res_tdata=eng_crc, res_tid=gidx, go to RESP.
- RESP:
  - res_tvalid=1. res_tdata/res_tid held stable while res_tvalid&&!res_tready.
  - On res_tready: res_tvalid=0, rr_ptr=(gidx+1) mod N_CH, grant=0, go to IDLE.
  - Earliest re-grant is the cycle after the handshake.
- Fairness: with all channels continuously requesting, the grant order is 0,1,2,...,N_CH-1,0.
- eng_crc_valid outside WAIT_RES is not accepted (eng_crc_ready=0). The engine must hold it.
- A single-beat frame (tlast on the first beat) goes directly STREAM→WAIT_RES.
- Reset mid-operation: the frame is abandoned, no result is emitted, all state returns to reset values.
- No combinational path from res_tready to s_tready.

Optional Feature:
- Macro: AXIS_CRC_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT_RES and increments each cycle there.
  - When it reaches MAX_WAIT without eng_crc_valid: emit result res_tdata=32'hFFFF_FFFF, res_tid=gidx, go to RESP.
  - Add output port err_timeout (1 bit). It pulses high for 1 cycle at the timeout and resets to 0.
- Undefined: no counter, no err_timeout port; WAIT_RES waits indefinitely.

Test Plan:
- Stub engine always ready, returns 0xDEADBEEF 3 cycles after tlast. Channel 1 sends 4 beats 0x11..0x14 → the engine sees exactly those 4 beats in order with tlast on the 4th; res_tdata=0xDEADBEEF, res_tid=1; grant=4'b0010 during the frame.
- All 4 channels send 1-beat frames simultaneously and continuously → res_tid sequence 0,1,2,3,0,1; no channel granted twice in a row while others are pending.
- Engine toggles eng_tready randomly, channel 2 sends a 6-beat frame → all 6 beats are delivered once, none dropped or duplicated; other s_tready bits stay 0 throughout.
- Hold res_tready=0 for 10 cycles in RESP → res_tvalid, res_tdata and res_tid stay stable; no new grant until the handshake.
- Assert aresetn=0 mid-frame (beat 2 of 5) → all outputs return to reset values immediately; after release, channel 0 is granted first when all request.
- With AXIS_CRC_ARB_TIMEOUT_EN and MAX_WAIT=16, the engine never returns a result → err_timeout pulses at cycle 16 of WAIT_RES; res_tdata=0xFFFFFFFF with the correct res_tid.
